axis_axil_write_bridge: RTL and testbench

AXIS_AXIL_WRITE_BRIDGE -- requirements
Module: axis_axil_write_bridge

---
 rtl/axil_bridge_pkg.sv | 25 ++
 rtl/axil_aw_w_tracker.sv | 57 +++++
 rtl/axis_axil_write_bridge.sv | 173 +++++++++++++++++
 tb/tb_axis_axil_write_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_bridge_pkg.sv
// rtl/axil_bridge_pkg.sv - shared types and constants for the AXI-Stream to AXI4-Lite write bridge
//
// Purpose : FSM state type, response codes, fixed AXI4-Lite attribute values
//           and the register-index width used by the bridge and its tracker.
// Ports   : none (package).
// Options : none here; the response-check feature is selected in the top
//           module by AXIL_BRIDGE_RESP_CHECK_EN.
package axil_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] WSTRB_ALL   = 4'hF;
  localparam logic [2:0] AWPROT_DATA = 3'b000;

  // Wide enough for register indices 0..255.
  localparam int IDX_W = 8;

endpackage

// File: rtl/axil_aw_w_tracker.sv
// rtl/axil_aw_w_tracker.sv - independent AW/W valid generation and handshake tracking
//
// Purpose : raises awvalid and wvalid one cycle after start, drops each on its
//           own handshake, and reports when both handshakes have happened.
// Ports   : clk, rst_n (async, active-low)
//           start          - pulse: a new word was accepted
//           awready/wready - slave readies
//           awvalid/wvalid - master valids
//           both_done      - both handshakes complete (including this cycle)
// Options : none.
module axil_aw_w_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic both_done
);

  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (start) begin
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
    end
  end

  // Folding in the current-cycle handshakes lets the FSM leave XFER on the
  // same edge as the last handshake instead of one cycle later.
  assign both_done = (aw_done | aw_hs) & (w_done | w_hs);

endmodule

// File: rtl/axis_axil_write_bridge.sv
// rtl/axis_axil_write_bridge.sv - writes each stream word to a ring of AXI4-Lite registers
//
// Purpose : accepts one 32-bit stream word at a time and writes it to
//           C_BASE_ADDR + 4*idx; idx advances per completed write, wraps at
//           C_NUM_REGS and returns to 0 after a word carrying tlast.
// Ports   : ACLK, ARESETN (async, active-low)
//           s_axis_tdata/tvalid/tready/tlast - input word stream
//           m_axi_aw*                        - write-address channel
//           m_axi_w*                         - write-data channel
//           m_axi_bresp/bvalid/bready        - write-response channel
//           words_written                    - completed writes (wraps)
//           err, err_clr                     - sticky bad-response flag and clear
// Options : AXIL_BRIDGE_RESP_CHECK_EN - when defined, a non-OKAY bresp sets err;
//           otherwise err is tied to 0 and bresp/err_clr are ignored.
module axis_axil_write_bridge
  import axil_bridge_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h0000_0000,
  parameter int                            C_NUM_REGS         = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,

  input  logic [C_M_AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,

  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,

  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,

  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,

  output logic [15:0]                   words_written,
  output logic                          err,
  input  logic                          err_clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_REGS - 1);

  bridge_state_t                 state;
  bridge_state_t                 state_nxt;
  logic                          out_of_reset;
  logic                          accept;
  logic                          complete;
  logic                          both_done;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              idx_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] data_q;
  logic                          last_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    m_axi_bready  = 1'b0;
    accept        = 1'b0;
    complete      = 1'b0;
    case (state)
      IDLE: begin
        // out_of_reset holds tready low until the first edge after reset.
        s_axis_tready = out_of_reset;
        if (out_of_reset && s_axis_tvalid) begin
          accept    = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (both_done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_comb begin
    idx_nxt = idx + 1'b1;
    if (last_q || (idx == LAST_IDX)) begin
      idx_nxt = '0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_of_reset  <= 1'b0;
      idx           <= '0;
      words_written <= 16'd0;
      addr_q        <= '0;
      data_q        <= '0;
      last_q        <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      if (accept) begin
        addr_q <= C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
        data_q <= s_axis_tdata;
        last_q <= s_axis_tlast;
      end
      if (complete) begin
        idx           <= idx_nxt;
        words_written <= words_written + 16'd1;
      end
    end
  end

  axil_aw_w_tracker u_tracker (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .start     (accept),
    .awready   (m_axi_awready),
    .wready    (m_axi_wready),
    .awvalid   (m_axi_awvalid),
    .wvalid    (m_axi_wvalid),
    .both_done (both_done)
  );

  assign m_axi_awaddr = addr_q;
  assign m_axi_awprot = AWPROT_DATA;
  assign m_axi_wdata  = data_q;
  assign m_axi_wstrb  = WSTRB_ALL;

  // ---------------------------------------------------- response checking
`ifdef AXIL_BRIDGE_RESP_CHECK_EN
  logic err_q;

  // A new bad response takes priority over a coincident clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_q <= 1'b0;
    end else if (complete && (m_axi_bresp != RESP_OKAY)) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_resp;

  assign unused_resp = &{1'b0, err_clr, m_axi_bresp};
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_axis_axil_write_bridge.sv
// tb/tb_axis_axil_write_bridge.sv - self-checking bench for axis_axil_write_bridge
`timescale 1ns/1ps
module tb_axis_axil_write_bridge;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int          NREG = 4;
`ifdef AXIL_BRIDGE_RESP_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic        tb_ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [15:0] words_written;
  logic        err, err_clr;

  always #5 tb_ACLK = ~tb_ACLK;

  axis_axil_write_bridge #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_BASE_ADDR        (BASE),
    .C_NUM_REGS         (NREG)
  ) dut (
    .ACLK          (tb_ACLK),
    .ARESETN       (ARESETN),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .words_written (words_written),
    .err           (err),
    .err_clr       (err_clr)
  );

  typedef struct packed { logic [31:0] data; logic last; } word_t;

  word_t       src_q[$];
  logic [31:0] exp_addr_q[$], exp_data_q[$], got_addr_q[$], got_data_q[$];
  logic [1:0]  resp_q[$];
  int  aw_pct = 100, w_pct = 100, src_pct = 100, b_lat = 0;
  bit  spur_b = 0;
  int  accepted, aw_cnt, w_cnt, b_done, b_wait, m_idx, mon_err;
  bit  s_fire, b_fire, b_real, aw_pend, w_pend, fired_s;
  logic [31:0] prev_awaddr, prev_wdata;
  string mon_msg = "";
  int  n_tests = 0, n_fail = 0;

  task automatic mon_note(input string s);
    mon_err++;
    if (mon_msg == "") mon_msg = s;
  endtask

  // Stream source, AXI4-Lite slave, scoreboard and protocol monitor.
  // Inputs change on the falling edge; handshakes are predicted 1 ns later.
  initial begin : bfm
    s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tlast = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00;
    forever begin
      @(negedge tb_ACLK);
      if (ARESETN !== 1'b1) begin
        s_axis_tvalid = 0; s_axis_tlast = 0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 2'b00;
        src_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
        got_addr_q.delete(); got_data_q.delete(); resp_q.delete();
        accepted = 0; aw_cnt = 0; w_cnt = 0; b_done = 0; b_wait = 0; m_idx = 0;
        s_fire = 0; b_fire = 0; b_real = 0; aw_pend = 0; w_pend = 0;
        continue;
      end
      if (b_fire) begin b_fire = 0; b_real = 0; m_axi_bvalid = 0; b_done++; end
      fired_s = s_fire;
      s_fire  = 0;
      if (fired_s) void'(src_q.pop_front());
      if (src_q.size() == 0) s_axis_tvalid = 0;
      else if ((s_axis_tvalid && !fired_s) || ($urandom_range(99) < src_pct)) begin
        s_axis_tvalid = 1; s_axis_tdata = src_q[0].data; s_axis_tlast = src_q[0].last;
      end else s_axis_tvalid = 0;
      m_axi_awready = ($urandom_range(99) < aw_pct);
      m_axi_wready  = ($urandom_range(99) < w_pct);
      if (spur_b) begin
        m_axi_bvalid = 1; m_axi_bresp = 2'b00;
      end else begin
        if (!b_real) m_axi_bvalid = 0;
        if (!b_real && aw_cnt > b_done && w_cnt > b_done) begin
          if (b_wait >= b_lat) begin
            m_axi_bvalid = 1; b_real = 1; b_wait = 0;
            m_axi_bresp = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
          end else b_wait++;
        end
      end
      #1;
      if (fired_s && !(m_axi_awvalid && m_axi_wvalid)) mon_note("valids not high the cycle after acceptance");
      if (s_axis_tready && accepted > b_done) mon_note("tready high with a write outstanding");
      if (m_axi_bready && !(aw_cnt > b_done && w_cnt > b_done)) mon_note("bready before both handshakes");
      if (aw_pend && (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr)) mon_note("AW changed before handshake");
      if (w_pend && (!m_axi_wvalid || m_axi_wdata !== prev_wdata)) mon_note("W changed before handshake");
      if (m_axi_awvalid && m_axi_awprot !== 3'b000) mon_note("awprot not 000");
      if (m_axi_wvalid && m_axi_wstrb !== 4'hF) mon_note("wstrb not F");
      if (s_axis_tvalid && s_axis_tready) begin
        s_fire = 1; accepted++;
        exp_addr_q.push_back(BASE + 32'(4 * m_idx));
        exp_data_q.push_back(s_axis_tdata);
        m_idx = s_axis_tlast ? 0 : (m_idx + 1) % NREG;
      end
      aw_pend = m_axi_awvalid && !m_axi_awready; prev_awaddr = m_axi_awaddr;
      w_pend  = m_axi_wvalid && !m_axi_wready;   prev_wdata  = m_axi_wdata;
      if (m_axi_awvalid && m_axi_awready) begin got_addr_q.push_back(m_axi_awaddr); aw_cnt++; end
      if (m_axi_wvalid && m_axi_wready) begin got_data_q.push_back(m_axi_wdata); w_cnt++; end
      if (!spur_b && m_axi_bvalid && m_axi_bready) b_fire = 1;
    end
  end

  task automatic push_word(input logic [31:0] d, input logic l);
    word_t w;
    w.data = d; w.last = l;
    src_q.push_back(w);
  endtask

  task automatic do_reset;
    ARESETN = 0; aw_pct = 100; w_pct = 100; src_pct = 100; b_lat = 0; spur_b = 0;
    repeat (2) @(negedge tb_ACLK);
    #2 ARESETN = 1;
    @(negedge tb_ACLK); #2;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (b_done < target && k < budget) begin @(negedge tb_ACLK); #2; k++; end
    if (b_done < target) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: completions=%0d required=%0d", name, b_done, target);
    end
  endtask

  task automatic test_reset;
    ARESETN = 0; err_clr = 0;
    repeat (2) @(negedge tb_ACLK); #1;
    n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got=%b exp=0", s_axis_tready); end
    n_tests++; if (m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid got=%b exp=0", m_axi_awvalid); end
    n_tests++; if (m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid got=%b exp=0", m_axi_wvalid); end
    n_tests++; if (m_axi_bready !== 1'b0) begin n_fail++; $display("FAIL reset_bready got=%b exp=0", m_axi_bready); end
    n_tests++; if (words_written !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", words_written); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge tb_ACLK); #2 ARESETN = 1; #1;
    n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL tready_before_edge got=%b exp=0", s_axis_tready); end
    @(posedge tb_ACLK); #1;
    n_tests++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL tready_first_edge got=%b exp=1", s_axis_tready); end
  endtask

  task automatic test_sequence;
    logic [31:0] words [4];
    words = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    do_reset();
    for (int i = 0; i < 4; i++) push_word(words[i], 1'b0);
    wait_done(4, 200, "sequence");
    n_tests++; if (got_addr_q.size() != 4) begin n_fail++; $display("FAIL seq_aw_count got=%0d exp=4", got_addr_q.size()); end
    for (int i = 0; i < 4 && i < got_addr_q.size() && i < got_data_q.size(); i++) begin
      n_tests++; if (got_addr_q[i] !== BASE + 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, got_addr_q[i], BASE + 32'(4 * i)); end
      n_tests++; if (got_data_q[i] !== words[i]) begin n_fail++; $display("FAIL seq_data[%0d] got=%h exp=%h", i, got_data_q[i], words[i]); end
    end
    n_tests++; if (words_written !== 16'd4) begin n_fail++; $display("FAIL seq_count got=%0d exp=4", words_written); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL seq_err got=%b exp=0", err); end
  endtask

  task automatic test_w_before_aw;
    int k = 0;
    do_reset();
    aw_pct = 0; w_pct = 100;
    push_word(32'h1234_5678, 1'b0);
    while (w_cnt < 1 && k < 50) begin @(negedge tb_ACLK); #2; k++; end
    n_tests++; if (w_cnt != 1) begin n_fail++; $display("FAIL wfirst_w_hs got=%0d exp=1", w_cnt); end
    for (int c = 0; c < 3; c++) begin
      @(negedge tb_ACLK); #2;
      n_tests++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b100) begin
        n_fail++; $display("FAIL wfirst_hold[%0d] aw/w/b got=%b exp=100", c, {m_axi_awvalid, m_axi_wvalid, m_axi_bready});
      end
    end
    aw_pct = 100;
    wait_done(1, 50, "wfirst");
    repeat (3) @(negedge tb_ACLK); #2;
    n_tests++; if (aw_cnt != 1 || w_cnt != 1) begin n_fail++; $display("FAIL wfirst_single aw=%0d w=%0d exp=1/1", aw_cnt, w_cnt); end
    n_tests++; if (words_written !== 16'd1) begin n_fail++; $display("FAIL wfirst_count got=%0d exp=1", words_written); end
    n_tests++; if (got_addr_q.size() < 1 || got_addr_q[0] !== BASE) begin n_fail++; $display("FAIL wfirst_addr size=%0d exp_addr=%h", got_addr_q.size(), BASE); end
  endtask

  task automatic test_tlast_wrap;
    int offs [5];
    offs = '{0, 4, 0, 4, 8};
    do_reset();
    for (int i = 0; i < 5; i++) push_word($urandom, i == 1);
    wait_done(5, 200, "tlast");
    n_tests++; if (got_addr_q.size() != 5) begin n_fail++; $display("FAIL tlast_aw_count got=%0d exp=5", got_addr_q.size()); end
    for (int i = 0; i < 5 && i < got_addr_q.size(); i++) begin
      n_tests++; if (got_addr_q[i] !== BASE + 32'(offs[i])) begin n_fail++; $display("FAIL tlast_addr[%0d] got=%h exp=%h", i, got_addr_q[i], BASE + 32'(offs[i])); end
    end
  endtask

  task automatic test_bresp;
    do_reset();
    resp_q.push_back(2'b00); resp_q.push_back(2'b10);
    push_word(32'hA5A5_0001, 1'b0);
    wait_done(1, 50, "bresp1");
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL bresp_ok_err got=%b exp=0", err); end
    push_word(32'hA5A5_0002, 1'b0);
    wait_done(2, 50, "bresp2");
    n_tests++; if (err !== ERR_ON) begin n_fail++; $display("FAIL bresp_slverr_err got=%b exp=%b", err, ERR_ON); end
    err_clr = 1;
    @(negedge tb_ACLK); #2;
    err_clr = 0;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL bresp_clr_err got=%b exp=0", err); end
    resp_q.push_back(2'b10);
    err_clr = 1;
    push_word(32'hA5A5_0003, 1'b0);
    wait_done(3, 50, "bresp3");
    err_clr = 0;
    n_tests++; if (err !== ERR_ON) begin n_fail++; $display("FAIL bresp_clr_collide got=%b exp=%b", err, ERR_ON); end
    n_tests++; if (words_written !== 16'd3) begin n_fail++; $display("FAIL bresp_count got=%0d exp=3", words_written); end
  endtask

  task automatic test_reset_in_resp;
    int k = 0;
    do_reset();
    push_word(32'h1111_0000, 1'b0);
    wait_done(1, 50, "rst_first");
    b_lat = 20;
    push_word(32'h2222_0000, 1'b0);
    while (m_axi_bready !== 1'b1 && k < 60) begin @(negedge tb_ACLK); #2; k++; end
    n_tests++; if (m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL rst_reach_resp bready=%b exp=1", m_axi_bready); end
    #1 ARESETN = 0;
    #1;
    n_tests++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_async aw/w/b/t got=%b exp=0000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready});
    end
    n_tests++; if (words_written !== 16'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", words_written); end
    repeat (2) @(negedge tb_ACLK);
    #2 ARESETN = 1; b_lat = 0;
    @(negedge tb_ACLK); #2;
    push_word(32'h3333_0000, 1'b0);
    wait_done(1, 50, "rst_next");
    n_tests++; if (got_addr_q.size() < 1 || got_addr_q[0] !== BASE) begin n_fail++; $display("FAIL rst_next_addr size=%0d exp_addr=%h", got_addr_q.size(), BASE); end
    n_tests++; if (words_written !== 16'd1) begin n_fail++; $display("FAIL rst_next_count got=%0d exp=1", words_written); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] sent [3];
    do_reset();
    b_lat = 10;
    for (int i = 0; i < 3; i++) begin sent[i] = $urandom; push_word(sent[i], 1'b0); end
    wait_done(3, 200, "backpressure");
    n_tests++; if (accepted != 3 || got_data_q.size() != 3) begin n_fail++; $display("FAIL bp_counts accepted=%0d written=%0d exp=3/3", accepted, got_data_q.size()); end
    for (int i = 0; i < 3 && i < got_data_q.size(); i++) begin
      n_tests++; if (got_data_q[i] !== sent[i]) begin n_fail++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_data_q[i], sent[i]); end
    end
    n_tests++; if (mon_err != 0) begin n_fail++; $display("FAIL bp_protocol errors=%0d exp=0 first=%s", mon_err, mon_msg); end
  endtask

  task automatic test_spurious_bvalid;
    do_reset();
    spur_b = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge tb_ACLK); #2;
      n_tests++; if ({s_axis_tready, m_axi_bready} !== 2'b10) begin n_fail++; $display("FAIL spur_idle t/b got=%b exp=10", {s_axis_tready, m_axi_bready}); end
    end
    spur_b = 0; aw_pct = 0;
    push_word(32'h5555_AAAA, 1'b0);
    repeat (4) @(negedge tb_ACLK); #2;
    spur_b = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge tb_ACLK); #2;
      n_tests++; if ({m_axi_awvalid, m_axi_bready} !== 2'b10) begin n_fail++; $display("FAIL spur_xfer aw/b got=%b exp=10", {m_axi_awvalid, m_axi_bready}); end
    end
    spur_b = 0;
    @(negedge tb_ACLK); #2;
    n_tests++; if (words_written !== 16'd0) begin n_fail++; $display("FAIL spur_count got=%0d exp=0", words_written); end
    aw_pct = 100;
    wait_done(1, 50, "spur_finish");
    n_tests++; if (words_written !== 16'd1) begin n_fail++; $display("FAIL spur_final_count got=%0d exp=1", words_written); end
  endtask

  task automatic test_random;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      aw_pct = $urandom_range(100, 25); w_pct = $urandom_range(100, 25);
      src_pct = $urandom_range(100, 30); b_lat = $urandom_range(3, 0);
      for (int i = 0; i < 10; i++) push_word($urandom, $urandom_range(3, 0) == 0);
      wait_done(10 * (b + 1), 2000, "random");
    end
    n_tests++; if (got_addr_q.size() != exp_addr_q.size() || got_data_q.size() != exp_data_q.size()) begin
      n_fail++; $display("FAIL rnd_sizes aw=%0d/%0d w=%0d/%0d", got_addr_q.size(), exp_addr_q.size(), got_data_q.size(), exp_data_q.size());
    end
    for (int i = 0; i < got_addr_q.size() && i < exp_addr_q.size() && i < got_data_q.size() && i < exp_data_q.size(); i++) begin
      n_tests++; if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i]) begin
        n_fail++; $display("FAIL rnd_write[%0d] got=%h:%h exp=%h:%h", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
    n_tests++; if (words_written !== 16'd40) begin n_fail++; $display("FAIL rnd_count got=%0d exp=40", words_written); end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    ARESETN = 0; err_clr = 0;
    test_reset();
    test_sequence();
    test_w_before_aw();
    test_tlast_wrap();
    test_bresp();
    test_reset_in_resp();
    test_back_to_back();
    test_spurious_bvalid();
    test_random();
    n_tests++; if (mon_err != 0) begin n_fail++; $display("FAIL protocol_monitor errors=%0d exp=0 first=%s", mon_err, mon_msg); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
